// File: rtl/flex_counter_pkg.sv
// Shared types for the flexible up/down counter.
package flex_counter_pkg;

  // Behaviour when the count reaches its terminal value; the reserved code acts as WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

endpackage : flex_counter_pkg

// File: rtl/tick_prescaler.sv
// Enable prescaler: produces one tick for every prescale+1 enabled cycles.
// The tick is combinational from the prescale register so the counter
// advances on the same edge that completes the prescale period.
module tick_prescaler #(
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [PRESCALE_BITS-1:0] prescale,
  output logic                     tick
);

  logic [PRESCALE_BITS-1:0] pre_q;
  logic [PRESCALE_BITS-1:0] pre_d;

  // Next prescale count and tick; clear wins, disabled cycles hold.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    pre_d = pre_q;
    tick  = 1'b0;
    if (clear) begin
      pre_d = '0;
    end else if (enable) begin
      if (pre_q == prescale) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (!n_rst) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule : tick_prescaler

// File: rtl/flex_updown_counter.sv
// Parametrised up/down counter/timer with load, wrap/saturate/one-shot
// terminal modes, an enable prescaler, a terminal pulse and a sticky wrap flag.
// All outputs are registered; there is no combinational input-to-output path.
module flex_updown_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS  = 8,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     dir,
  input  logic [1:0]               mode,
  input  logic [PRESCALE_BITS-1:0] prescale,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     term_pulse,
  output logic                     halted,
  output logic                     wrapped
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;
  logic                    halted_q, halted_d;
  logic                    wrapped_q, wrapped_d;

  logic                    tick;
  logic                    pre_clear;
  logic                    pre_enable;

  // Load restarts the prescale period just like clear; a halted one-shot ignores enables.
  assign pre_clear  = clear | load;
  assign pre_enable = count_enable & ~halted_q;

  tick_prescaler #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (pre_clear),
    .enable   (pre_enable),
    .prescale (prescale),
    .tick     (tick)
  );

  mode_t                   mode_e;
  logic                    hold_mode;
  logic                    rv_zero;
  logic [NUM_CNT_BITS-1:0] term;
  logic [NUM_CNT_BITS-1:0] step_cnt;
  logic                    wrap_evt;

  // Next-state: clear > load > tick > hold, with the tick's count result precomputed.
  always_comb begin
    mode_e    = mode_t'(mode);
    hold_mode = (mode_e == MODE_SAT) || (mode_e == MODE_ONESHOT);
    rv_zero   = (rollover_val == '0);
    term      = dir ? rollover_val : ONE;

    step_cnt = count_q;
    wrap_evt = 1'b0;
    if (rv_zero) begin
      step_cnt = '0;
    end else if (dir) begin
      if (count_q < rollover_val) begin
        step_cnt = count_q + ONE;
      end else if (hold_mode) begin
        step_cnt = rollover_val;
      end else begin
        step_cnt = ONE;
        wrap_evt = 1'b1;
      end
    end else begin
      if (count_q == '0 || count_q > rollover_val) begin
        step_cnt = rollover_val;
      end else if (count_q > ONE) begin
        step_cnt = count_q - ONE;
      end else if (hold_mode) begin
        step_cnt = ONE;
      end else begin
        step_cnt = rollover_val;
        wrap_evt = 1'b1;
      end
    end

    count_d   = count_q;
    flag_d    = 1'b0;
    pulse_d   = 1'b0;
    halted_d  = halted_q;
    wrapped_d = wrapped_q;

    if (clear) begin
      count_d   = '0;
      halted_d  = 1'b0;
      wrapped_d = 1'b0;
    end else if (load) begin
      count_d   = load_val;
      halted_d  = 1'b0;
      wrapped_d = 1'b0;
      flag_d    = !rv_zero && (load_val == term);
    end else begin
      if (tick) begin
        count_d   = step_cnt;
        wrapped_d = wrapped_q | wrap_evt;
        // A clamped hold at the terminal value must not pulse again.
        pulse_d   = !rv_zero && (step_cnt == term) && (!hold_mode || count_q != term);
        if (mode_e == MODE_ONESHOT && !rv_zero && step_cnt == term) halted_d = 1'b1;
      end
      flag_d = !rv_zero && (count_d == term);
    end
  end

  // State registers; asynchronous reset returns every output to zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q   <= '0;
      flag_q    <= 1'b0;
      pulse_q   <= 1'b0;
      halted_q  <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      flag_q    <= flag_d;
      pulse_q   <= pulse_d;
      halted_q  <= halted_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign term_pulse    = pulse_q;
  assign halted        = halted_q;
  assign wrapped       = wrapped_q;

endmodule : flex_updown_counter

// File: tb/tb_flex_updown_counter.sv
// Self-checking bench for flex_updown_counter: directed scenarios plus
// randomized stimulus compared against an integer reference model.
module tb_flex_updown_counter;

  localparam int NB = 8;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [NB-1:0] load_val = '0;
  logic          count_enable = 1'b0;
  logic          dir = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [PB-1:0] prescale = '0;
  logic [NB-1:0] rollover_val = '0;
  logic [NB-1:0] count_out;
  logic          rollover_flag;
  logic          term_pulse;
  logic          halted;
  logic          wrapped;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, kept as plain integers.
  int m_count, m_pre;
  bit m_flag, m_pulse, m_halted, m_wrapped;

  flex_updown_counter #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .load          (load),
    .load_val      (load_val),
    .count_enable  (count_enable),
    .dir           (dir),
    .mode          (mode),
    .prescale      (prescale),
    .rollover_val  (rollover_val),
    .count_out     (count_out),
    .rollover_flag (rollover_flag),
    .term_pulse    (term_pulse),
    .halted        (halted),
    .wrapped       (wrapped)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_count = 0; m_pre = 0;
    m_flag = 0; m_pulse = 0; m_halted = 0; m_wrapped = 0;
  endtask

  // One clock of the counter's rules, applied to the inputs about to be sampled.
  task automatic model_step();
    int  rv, c, term, nxt;
    bit  tk, hold_mode;
    rv        = int'(rollover_val);
    c         = m_count;
    term      = dir ? rv : 1;
    hold_mode = (mode == 2'b01) || (mode == 2'b10);
    tk        = 0;
    if (clear) begin
      model_reset();
      return;
    end
    if (load) begin
      m_count = int'(load_val); m_pre = 0;
      m_halted = 0; m_wrapped = 0; m_pulse = 0;
      m_flag = (rv != 0) && (m_count == term);
      return;
    end
    if (count_enable && !m_halted) begin
      if (m_pre == int'(prescale)) begin tk = 1; m_pre = 0; end
      else m_pre = (m_pre + 1) % (1 << PB);
    end
    nxt = c;
    m_pulse = 0;
    if (tk) begin
      if (rv == 0) nxt = 0;
      else if (dir) begin
        if (c < rv) nxt = c + 1;
        else if (hold_mode) nxt = rv;
        else begin nxt = 1; m_wrapped = 1; end
      end else begin
        if (c == 0 || c > rv) nxt = rv;
        else if (c > 1) nxt = c - 1;
        else if (hold_mode) nxt = 1;
        else begin nxt = rv; m_wrapped = 1; end
      end
      if (rv != 0 && nxt == term && (!hold_mode || c != term)) m_pulse = 1;
      if (mode == 2'b10 && rv != 0 && nxt == term) m_halted = 1;
    end
    m_count = nxt;
    m_flag  = (rv != 0) && (nxt == term);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic do_clk();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; load = 1'b0;
    do_clk();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({count_out, rollover_flag, term_pulse, halted, wrapped} !== '0) begin
      n_fail++;
      $display("FAIL reset: outputs %h/%b%b%b%b expected all zero",
               count_out, rollover_flag, term_pulse, halted, wrapped);
    end
    model_reset();
    n_rst = 1'b1;
  endtask

  task automatic test_up_wrap();
    int exp_cnt[8] = '{1, 2, 3, 4, 5, 1, 2, 3};
    do_clear();
    mode = 2'b00; dir = 1'b1; rollover_val = 8'd5; prescale = '0; count_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_clk();
      n_tests++;
      if (count_out !== NB'(exp_cnt[i]) || rollover_flag !== (exp_cnt[i] == 5) ||
          term_pulse !== (exp_cnt[i] == 5) || wrapped !== (i >= 5)) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: cnt=%0d flag=%b pulse=%b wrap=%b expected cnt=%0d flag=%b pulse=%b wrap=%b",
                 i, count_out, rollover_flag, term_pulse, wrapped,
                 exp_cnt[i], exp_cnt[i] == 5, exp_cnt[i] == 5, i >= 5);
      end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_down_wrap();
    int exp_cnt[5] = '{3, 2, 1, 3, 2};
    do_clear();
    mode = 2'b00; dir = 1'b0; rollover_val = 8'd3; prescale = '0; count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_clk();
      n_tests++;
      if (count_out !== NB'(exp_cnt[i]) || rollover_flag !== (exp_cnt[i] == 1) ||
          term_pulse !== (exp_cnt[i] == 1) || wrapped !== (i >= 3)) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: cnt=%0d flag=%b pulse=%b wrap=%b expected cnt=%0d flag=%b pulse=%b wrap=%b",
                 i, count_out, rollover_flag, term_pulse, wrapped,
                 exp_cnt[i], exp_cnt[i] == 1, exp_cnt[i] == 1, i >= 3);
      end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_up_sat();
    int pulses = 0;
    int exp_c;
    do_clear();
    mode = 2'b01; dir = 1'b1; rollover_val = 8'd4; prescale = '0; count_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_clk();
      if (term_pulse === 1'b1) pulses++;
      exp_c = (i + 1 < 4) ? i + 1 : 4;
      n_tests++;
      if (count_out !== NB'(exp_c) || rollover_flag !== (exp_c == 4) || wrapped !== 1'b0) begin
        n_fail++;
        $display("FAIL up_sat[%0d]: cnt=%0d flag=%b wrap=%b expected cnt=%0d flag=%b wrap=0",
                 i, count_out, rollover_flag, wrapped, exp_c, exp_c == 4);
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL up_sat_pulses: got %0d expected 1", pulses);
    end
    count_enable = 1'b0;
  endtask

  task automatic test_oneshot();
    int exp_c;
    do_clear();
    mode = 2'b10; dir = 1'b1; rollover_val = 8'd3; prescale = 4'd2; count_enable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      do_clk();
      exp_c = (k >= 9) ? 3 : k / 3;
      n_tests++;
      if (count_out !== NB'(exp_c) || halted !== (k >= 9)) begin
        n_fail++;
        $display("FAIL oneshot[%0d]: cnt=%0d halted=%b expected cnt=%0d halted=%b",
                 k, count_out, halted, exp_c, k >= 9);
      end
    end
    load = 1'b1; load_val = 8'd1;
    do_clk();
    load = 1'b0;
    n_tests++;
    if (count_out !== 8'd1 || halted !== 1'b0 || rollover_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_reload: cnt=%0d halted=%b flag=%b expected cnt=1 halted=0 flag=0",
               count_out, halted, rollover_flag);
    end
    count_enable = 1'b0;
  endtask

  task automatic test_clear_load();
    mode = 2'b00; dir = 1'b1; rollover_val = 8'd7; prescale = '0;
    clear = 1'b1; load = 1'b1; load_val = 8'd9; count_enable = 1'b1;
    do_clk();
    n_tests++;
    if (count_out !== 8'd0 || rollover_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_over_load: cnt=%0d flag=%b expected cnt=0 flag=0", count_out, rollover_flag);
    end
    clear = 1'b0; load_val = 8'd7;
    do_clk();
    n_tests++;
    if (count_out !== 8'd7 || rollover_flag !== 1'b1 || term_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL load_term: cnt=%0d flag=%b pulse=%b expected cnt=7 flag=1 pulse=0",
               count_out, rollover_flag, term_pulse);
    end
    load = 1'b0; rollover_val = 8'd4;
    do_clk();
    n_tests++;
    if (count_out !== 8'd1 || wrapped !== 1'b1) begin
      n_fail++;
      $display("FAIL above_rv_wrap: cnt=%0d wrap=%b expected cnt=1 wrap=1", count_out, wrapped);
    end
    load = 1'b1; mode = 2'b01;
    do_clk();
    load = 1'b0;
    do_clk();
    n_tests++;
    if (count_out !== 8'd4 || rollover_flag !== 1'b1 || term_pulse !== 1'b1 || wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL above_rv_sat: cnt=%0d flag=%b pulse=%b wrap=%b expected cnt=4 flag=1 pulse=1 wrap=0",
               count_out, rollover_flag, term_pulse, wrapped);
    end
    count_enable = 1'b0;
  endtask

  task automatic test_async_reset();
    int exp_c;
    do_clear();
    mode = 2'b00; dir = 1'b1; rollover_val = 8'd20; prescale = 4'd3; count_enable = 1'b1;
    for (int i = 0; i < 38; i++) do_clk();
    n_tests++;
    if (count_out !== 8'd9) begin
      n_fail++;
      $display("FAIL pre_reset_count: got %0d expected 9", count_out);
    end
    #2;
    n_rst = 1'b0;
    #1;
    n_tests++;
    if ({count_out, rollover_flag, term_pulse, halted, wrapped} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: outputs %h/%b%b%b%b expected all zero",
               count_out, rollover_flag, term_pulse, halted, wrapped);
    end
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      do_clk();
      exp_c = (i == 4) ? 1 : 0;
      n_tests++;
      if (count_out !== NB'(exp_c)) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: cnt=%0d expected %0d", i, count_out, exp_c);
      end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_random();
    int rv_pick[8] = '{0, 1, 2, 3, 5, 7, 15, 200};
    do_clear();
    for (int i = 0; i < 600; i++) begin
      clear        = ($urandom_range(99) < 3);
      load         = ($urandom_range(99) < 5);
      load_val     = ($urandom_range(3) == 0) ? NB'($urandom_range(255)) : NB'($urandom_range(16));
      count_enable = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 10) dir = ~dir;
      if ($urandom_range(99) < 3)  mode = 2'($urandom_range(3));
      if ($urandom_range(99) < 3)  rollover_val = NB'(rv_pick[$urandom_range(7)]);
      if ($urandom_range(99) < 3)  prescale = PB'($urandom_range(3));
      do_clk();
      n_tests++;
      if (int'(count_out) != m_count || rollover_flag !== m_flag || term_pulse !== m_pulse ||
          halted !== m_halted || wrapped !== m_wrapped) begin
        n_fail++;
        $display("FAIL random[%0d]: cnt=%0d flag=%b pulse=%b halt=%b wrap=%b expected cnt=%0d flag=%b pulse=%b halt=%b wrap=%b",
                 i, count_out, rollover_flag, term_pulse, halted, wrapped,
                 m_count, m_flag, m_pulse, m_halted, m_wrapped);
      end
    end
    clear = 1'b0; load = 1'b0; count_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_up_sat();
    test_oneshot();
    test_clear_load();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_flex_updown_counter
